// File: rtl/i2c_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one i2c_controller among N_REQ clients.
// Optional watchdog: define I2C_ARB_TIMEOUT_EN to abort a stuck transaction after TIMEOUT_CYCLES.
module i2c_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 200_000
) (
    input  logic                     CLK,
    input  logic                     NRST,
    input  logic [N_REQ-1:0]         REQ,
    input  logic [7*N_REQ-1:0]       REQ_ADDR,
    input  logic [8*N_REQ-1:0]       REQ_DATA,
    input  logic [N_REQ-1:0]         REQ_RW,
    output logic [N_REQ-1:0]         ACK,
    output logic [N_REQ-1:0]         ERR,
    output logic [7:0]               RDATA,
    output logic [$clog2(N_REQ)-1:0] GNT_ID,
    output logic                     GNT_VALID,
    output logic [7:0]               C_IDATA,
    output logic [6:0]               C_IADDR,
    output logic                     C_RW,
    output logic                     C_IDRDY,
    input  logic                     C_BUSY,
    input  logic [7:0]               C_ODATA,
    input  logic                     C_ODRDY
);

    // state       | meaning
    // S_IDLE      | bus free check, round-robin grant
    // S_LAUNCH    | IDRDY pulse issued, drop it next
    // S_WAIT_BUSY | wait for controller to report busy
    // S_WAIT_DONE | capture read data, wait for busy to fall
    // S_RESP      | ACK/ERR pulse to the granted requester

    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t           state, state_nxt;
    logic [ID_W-1:0]  last, last_nxt;
    logic [N_REQ-1:0] ack_nxt, err_nxt;
    logic [7:0]       rdata_nxt, idata_nxt;
    logic [6:0]       iaddr_nxt;
    logic [ID_W-1:0]  gnt_id_nxt;
    logic             gnt_valid_nxt, rw_nxt, idrdy_nxt;
    logic             found;
    logic [ID_W-1:0]  win;
    logic [ID_W:0]    cand;
    logic             tmo;

    // Search downward so the candidate closest to last+1 is assigned last and wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = {1'b0, last} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(N_REQ))
                cand = cand - (ID_W+1)'(N_REQ);
            if (REQ[cand[ID_W-1:0]]) begin
                found = 1'b1;
                win   = cand[ID_W-1:0];
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] tmr;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST)
            tmr <= '0;
        else if (state == S_LAUNCH)
            tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
        else if ((state == S_WAIT_BUSY || state == S_WAIT_DONE) && tmr != '0)
            tmr <= tmr - TMR_W'(1);
    end

    assign tmo = (state == S_WAIT_BUSY || state == S_WAIT_DONE) && (tmr == '0);
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
    assign tmo            = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        last_nxt      = last;
        ack_nxt       = '0;
        err_nxt       = '0;
        rdata_nxt     = RDATA;
        gnt_id_nxt    = GNT_ID;
        gnt_valid_nxt = GNT_VALID;
        idata_nxt     = C_IDATA;
        iaddr_nxt     = C_IADDR;
        rw_nxt        = C_RW;
        idrdy_nxt     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!C_BUSY && found) begin
                    iaddr_nxt     = REQ_ADDR[int'(win)*7 +: 7];
                    idata_nxt     = REQ_DATA[int'(win)*8 +: 8];
                    rw_nxt        = REQ_RW[win];
                    gnt_id_nxt    = win;
                    gnt_valid_nxt = 1'b1;
                    idrdy_nxt     = 1'b1;
                    state_nxt     = S_LAUNCH;
                end
            end
            S_LAUNCH: state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (C_BUSY) begin
                    state_nxt = S_WAIT_DONE;
                end else if (tmo) begin
                    ack_nxt[GNT_ID] = 1'b1;
                    err_nxt[GNT_ID] = 1'b1;
                    last_nxt        = GNT_ID;
                    state_nxt       = S_RESP;
                end
            end
            S_WAIT_DONE: begin
                // A timeout leaves RDATA untouched; a busy fall wins over a timeout.
                if (C_ODRDY && !(C_BUSY && tmo))
                    rdata_nxt = C_ODATA;
                if (!C_BUSY) begin
                    ack_nxt[GNT_ID] = 1'b1;
                    last_nxt        = GNT_ID;
                    state_nxt       = S_RESP;
                end else if (tmo) begin
                    ack_nxt[GNT_ID] = 1'b1;
                    err_nxt[GNT_ID] = 1'b1;
                    last_nxt        = GNT_ID;
                    state_nxt       = S_RESP;
                end
            end
            S_RESP: begin
                gnt_valid_nxt = 1'b0;
                state_nxt     = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state     <= S_IDLE;
            last      <= ID_W'(N_REQ - 1);
            ACK       <= '0;
            ERR       <= '0;
            RDATA     <= '0;
            GNT_ID    <= '0;
            GNT_VALID <= 1'b0;
            C_IDATA   <= '0;
            C_IADDR   <= '0;
            C_RW      <= 1'b0;
            C_IDRDY   <= 1'b0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            ACK       <= ack_nxt;
            ERR       <= err_nxt;
            RDATA     <= rdata_nxt;
            GNT_ID    <= gnt_id_nxt;
            GNT_VALID <= gnt_valid_nxt;
            C_IDATA   <= idata_nxt;
            C_IADDR   <= iaddr_nxt;
            C_RW      <= rw_nxt;
            C_IDRDY   <= idrdy_nxt;
        end
    end

endmodule
